// File: rtl/ysyx_040066_pkg.sv
// Shared widths and op encodings used by the multiplier
// issue stage and the Booth/Wallace array.
package ysyx_040066_pkg;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

endpackage

// File: rtl/ysyx_040066_booth_walloc.sv
// Two-stage radix-4 Booth multiplier array. Operands are captured
// in clk0, reduced and selected into the result register in clk1.
import ysyx_040066_pkg::*;

module ysyx_040066_booth_walloc (
    input  logic            clk,
    input  logic            block,
    input  logic [XLEN-1:0] src1_in,
    input  logic [XLEN-1:0] src2_in,
    input  logic [1:0]      ALUctr_in,
    input  logic [1:0]      ALUctr,
    input  logic            is_w,
    output logic [XLEN-1:0] result
);

    // Operands widened to an even width so the Booth recoding
    // covers both signed and zero-extended unsigned inputs.
    localparam int OW  = XLEN + 2;
    localparam int PW  = 2 * OW;
    localparam int NPP = OW / 2;

    logic [OW-1:0]   a_q, a_d;
    logic [OW-1:0]   b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            a_sgn;
    logic            b_sgn;
    logic [PW-1:0]   prod;
    logic [PW-1:0]   ae;
    logic [PW-1:0]   pp;
    logic [OW:0]     bp;
    logic [2:0]      trip;
    logic [XLEN-1:0] sel;

    always_comb begin
        a_sgn = (ALUctr_in == MUL_OP_MULH) ||
                (ALUctr_in == MUL_OP_MULHSU);
        b_sgn = (ALUctr_in == MUL_OP_MULH);
        a_d   = a_q;
        b_d   = b_q;
        if (!block) begin
            a_d = {{2{a_sgn & src1_in[XLEN-1]}}, src1_in};
            b_d = {{2{b_sgn & src2_in[XLEN-1]}}, src2_in};
        end
    end

    always_comb begin
        prod = '0;
        pp   = '0;
        trip = '0;
        ae   = {{(PW-OW){a_q[OW-1]}}, a_q};
        bp   = {b_q, 1'b0};
        for (int i = 0; i < NPP; i++) begin
            trip = bp[2*i +: 3];
            unique case (trip)
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae << 1;
                3'b100:         pp = -(ae << 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            prod = prod + (pp << (2 * i));
        end
    end

    always_comb begin
        sel = prod[2*XLEN-1:XLEN];
        if (ALUctr == MUL_OP_MUL) begin
            if (is_w) begin
                sel = {{(XLEN-32){prod[31]}}, prod[31:0]};
            end else begin
                sel = prod[XLEN-1:0];
            end
        end
        res_d = block ? res_q : sel;
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign result = res_q;

endmodule

// File: rtl/ysyx_040066_mul_issue.sv
// Issue stage for the 2-cycle RV64M multiplier: valid/tag
// tracking, backpressure stall and flush around the array.
import ysyx_040066_pkg::*;

module ysyx_040066_mul_issue (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_is_w,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [1:0]       op_s1_q, op_s1_d;
    logic             is_w_s1_q, is_w_s1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    logic stall;
    logic block;
    logic accept;
    logic arr_is_w;

    always_comb begin
        stall     = v2_q && !out_ready;
        block     = stall && !flush;
        accept    = in_valid && !stall && !flush;
        v1_d      = v1_q;
        v2_d      = v2_q;
        op_s1_d   = op_s1_q;
        is_w_s1_d = is_w_s1_q;
        tag1_d    = tag1_q;
        tag2_d    = tag2_q;
        // S1 control follows the array, which advances whenever unblocked.
        if (!block) begin
            op_s1_d   = in_op;
            is_w_s1_d = in_is_w;
            tag1_d    = in_tag;
            tag2_d    = tag1_q;
            v1_d      = accept;
            v2_d      = v1_q && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            op_s1_q   <= MUL_OP_MUL;
            is_w_s1_q <= 1'b0;
            tag1_q    <= '0;
            tag2_q    <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            op_s1_q   <= op_s1_d;
            is_w_s1_q <= is_w_s1_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
        end
    end

    assign arr_is_w = is_w_s1_q && (op_s1_q == MUL_OP_MUL);

    ysyx_040066_booth_walloc u_array (
        .clk       (clk),
        .block     (block),
        .src1_in   (in_src1),
        .src2_in   (in_src2),
        .ALUctr_in (in_op),
        .ALUctr    (op_s1_q),
        .is_w      (arr_is_w),
        .result    (out_result)
    );

    assign in_ready  = !stall;
    assign out_valid = v2_q;
    assign out_tag   = tag2_q;

endmodule

// File: tb/tb_ysyx_040066_mul_issue.sv
// Directed bench for the multiplier issue stage.
module tb_ysyx_040066_mul_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_is_w;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    ysyx_040066_mul_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_is_w    (in_is_w),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_is_w  = w;
        in_src1  = a;
        in_src2  = b;
        in_tag   = t;
    endtask

    task automatic run_one(input string name, input logic [1:0] op,
                           input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] t,
                           input logic [63:0] exp);
        drive(1'b1, op, w, a, b, t);
        #1;
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        cyc();
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        #1;
        chk({name, "_lat1_valid"}, {63'd0, out_valid}, 64'd0);
        cyc();
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_result"}, out_result, exp);
        chk({name, "_tag"}, {59'd0, out_tag}, {59'd0, t});
        cyc();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        cyc();

        run_one("mul", 2'b00, 1'b0, 64'd3, -64'sd5, 5'd7,
                64'hFFFF_FFFF_FFFF_FFF1);
        run_one("mulh", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd2,
                5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("mulhu", 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'd2,
                5'd2, 64'h0000_0000_0000_0001);
        run_one("mulhsu", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("mulw", 2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4,
                64'hFFFF_FFFF_FFFF_FFFE);
        run_one("mulhu_w_ign", 2'b11, 1'b1, 64'h8000_0000_0000_0000,
                64'd2, 5'd5, 64'h0000_0000_0000_0001);
        run_one("mul64", 2'b00, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001,
                5'd6, 64'h0000_0002_0000_0001);

        // Back-to-back: four ops, one per cycle.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(1'b1, 2'b00, 1'b0, 64'(i + 2), 64'(i + 3),
                      5'(10 + i));
            end else begin
                drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
            end
            #1;
            chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
            if (i >= 2) begin
                chk("b2b_valid", {63'd0, out_valid}, 64'd1);
                chk("b2b_result", out_result, 64'((i) * (i + 1)));
                chk("b2b_tag", {59'd0, out_tag}, 64'(8 + i));
            end
            cyc();
        end
        chk("b2b_drain", {63'd0, out_valid}, 64'd0);

        // Stall with two ops in flight.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 64'd5, 64'd6, 5'd1);
        cyc();
        drive(1'b1, 2'b00, 1'b0, 64'd7, 64'd8, 5'd2);
        cyc();
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_result", out_result, 64'd30);
            chk("stall_tag", {59'd0, out_tag}, 64'd1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {63'd0, in_ready}, 64'd1);
        chk("unstall_a_result", out_result, 64'd30);
        cyc();
        chk("unstall_b_valid", {63'd0, out_valid}, 64'd1);
        chk("unstall_b_result", out_result, 64'd56);
        chk("unstall_b_tag", {59'd0, out_tag}, 64'd2);
        cyc();
        chk("unstall_drain", {63'd0, out_valid}, 64'd0);

        // Flush while stalled with two in flight.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 64'd9, 64'd9, 5'd3);
        cyc();
        drive(1'b1, 2'b00, 1'b0, 64'd4, 64'd4, 5'd4);
        cyc();
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        cyc();
        chk("pre_flush_valid", {63'd0, out_valid}, 64'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);

        // Op offered in a flush cycle is dropped.
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 2'b00, 1'b0, 64'd3, 64'd3, 5'd8);
        #1;
        chk("flush_op_in_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        flush = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        cyc();
        chk("flush_drop_valid", {63'd0, out_valid}, 64'd0);
        cyc();
        chk("flush_drop_valid2", {63'd0, out_valid}, 64'd0);

        // Async reset with a result held in S2.
        drive(1'b1, 2'b00, 1'b0, 64'd4, 64'd4, 5'd9);
        cyc();
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 5'd0);
        cyc();
        chk("prerst_valid", {63'd0, out_valid}, 64'd1);
        chk("prerst_result", out_result, 64'd16);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_tag", {59'd0, out_tag}, 64'd0);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("postrst_valid", {63'd0, out_valid}, 64'd0);
        chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
